// File: rtl/operand_issue_stage_if.sv
// -----------------------------------------------------------------------------
// operand_issue_stage_if
// Bundles the decode-side handshake, operand sources, bypass channels and the
// execute-side handshake of operand_issue_stage.
//   master : upstream/decode + execute side (drives ops, bypasses, out_ready)
//   slave  : the issue stage itself
// Optional macro: OPERAND_ISSUE_STATS_EN adds io_stat_issued / io_stat_stall.
// -----------------------------------------------------------------------------
interface operand_issue_stage_if #(
    parameter int XLEN    = 32,
    parameter int NUM_BYP = 2,
    parameter int REG_AW  = 5
);
    logic                      io_in_valid;
    logic                      io_in_ready;
    logic [2:0]                io_data_control;
    logic [REG_AW-1:0]         io_rs1_addr;
    logic [REG_AW-1:0]         io_rs2_addr;
    logic [XLEN-1:0]           io_rs1_data;
    logic [XLEN-1:0]           io_rs2_data;
    logic [XLEN-1:0]           io_imm;
    logic [XLEN-1:0]           io_mem_data;
    logic [XLEN-1:0]           io_pc_count;
    logic [NUM_BYP-1:0]        io_byp_valid;
    logic [NUM_BYP*REG_AW-1:0] io_byp_rd;
    logic [NUM_BYP*XLEN-1:0]   io_byp_data;
    logic                      io_out_valid;
    logic                      io_out_ready;
    logic [XLEN-1:0]           io_data_1;
    logic [XLEN-1:0]           io_data_2;
    logic                      io_illegal;
`ifdef OPERAND_ISSUE_STATS_EN
    logic [31:0]               io_stat_issued;
    logic [31:0]               io_stat_stall;

    modport master (
        output io_in_valid, io_data_control, io_rs1_addr, io_rs2_addr,
               io_rs1_data, io_rs2_data, io_imm, io_mem_data, io_pc_count,
               io_byp_valid, io_byp_rd, io_byp_data, io_out_ready,
        input  io_in_ready, io_out_valid, io_data_1, io_data_2, io_illegal,
               io_stat_issued, io_stat_stall
    );

    modport slave (
        input  io_in_valid, io_data_control, io_rs1_addr, io_rs2_addr,
               io_rs1_data, io_rs2_data, io_imm, io_mem_data, io_pc_count,
               io_byp_valid, io_byp_rd, io_byp_data, io_out_ready,
        output io_in_ready, io_out_valid, io_data_1, io_data_2, io_illegal,
               io_stat_issued, io_stat_stall
    );
`else
    modport master (
        output io_in_valid, io_data_control, io_rs1_addr, io_rs2_addr,
               io_rs1_data, io_rs2_data, io_imm, io_mem_data, io_pc_count,
               io_byp_valid, io_byp_rd, io_byp_data, io_out_ready,
        input  io_in_ready, io_out_valid, io_data_1, io_data_2, io_illegal
    );

    modport slave (
        input  io_in_valid, io_data_control, io_rs1_addr, io_rs2_addr,
               io_rs1_data, io_rs2_data, io_imm, io_mem_data, io_pc_count,
               io_byp_valid, io_byp_rd, io_byp_data, io_out_ready,
        output io_in_ready, io_out_valid, io_data_1, io_data_2, io_illegal
    );
`endif
endinterface

// File: rtl/operand_issue_stage.sv
// -----------------------------------------------------------------------------
// operand_issue_stage
// Registered ALU operand selector between decode and execute. Accepts one op
// per cycle (valid/ready), forwards later-stage results onto rs1/rs2 and
// presents data_1/data_2 from a single pipeline register one cycle after
// acceptance.
//
// Ports
//   clock  : system clock
//   reset  : synchronous, active-high
//   bus    : operand_issue_stage_if.slave
//            in  : io_in_valid, io_data_control[2:0], io_rs1/2_addr,
//                  io_rs1/2_data, io_imm, io_mem_data, io_pc_count,
//                  io_byp_valid/rd/data, io_out_ready
//            out : io_in_ready, io_out_valid, io_data_1, io_data_2,
//                  io_illegal (sticky until reset)
//            opt : io_stat_issued, io_stat_stall
//
// Optional macro: OPERAND_ISSUE_STATS_EN adds the issued/stall counters.
//
// Modes (data_1 / data_2):
//   0 OP_IMM r1/imm   1 AUIPC pc/imm   2 LOAD mem/0   3 OP r1/r2
//   4 LINK pc/PC_STEP 5 LUI 0/imm      6,7 illegal 0/0 (still issues)
// -----------------------------------------------------------------------------
module operand_issue_stage #(
    parameter int XLEN    = 32,
    parameter int NUM_BYP = 2,
    parameter int REG_AW  = 5,
    parameter int PC_STEP = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    operand_issue_stage_if.slave  bus
);

    typedef enum logic [2:0] {
        MODE_OP_IMM = 3'd0,
        MODE_AUIPC  = 3'd1,
        MODE_LOAD   = 3'd2,
        MODE_OP     = 3'd3,
        MODE_LINK   = 3'd4,
        MODE_LUI    = 3'd5,
        MODE_ILL6   = 3'd6,
        MODE_ILL7   = 3'd7
    } mode_e;

    mode_e            mode;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  data_1_q, data_1_d;
    logic [XLEN-1:0]  data_2_q, data_2_d;
    logic             illegal_q, illegal_d;
    logic [XLEN-1:0]  r1, r2;
    logic             in_ready;
    logic             accept;
    logic             out_fire;

    assign mode     = mode_e'(bus.io_data_control);
    assign in_ready = !valid_q || bus.io_out_ready;
    assign accept   = bus.io_in_valid && in_ready;
    assign out_fire = valid_q && bus.io_out_ready;

    // Walk channels from oldest to youngest so the lowest matching channel
    // overwrites last and wins. Register 0 is hardwired and never forwarded.
    always_comb begin
        r1 = bus.io_rs1_data;
        r2 = bus.io_rs2_data;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (bus.io_byp_valid[i] && (bus.io_rs1_addr != '0) &&
                (bus.io_byp_rd[i*REG_AW +: REG_AW] == bus.io_rs1_addr)) begin
                r1 = bus.io_byp_data[i*XLEN +: XLEN];
            end
            if (bus.io_byp_valid[i] && (bus.io_rs2_addr != '0) &&
                (bus.io_byp_rd[i*REG_AW +: REG_AW] == bus.io_rs2_addr)) begin
                r2 = bus.io_byp_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        valid_d   = valid_q;
        data_1_d  = data_1_q;
        data_2_d  = data_2_q;
        illegal_d = illegal_q;
        if (accept) begin
            valid_d = 1'b1;
            unique case (mode)
                MODE_OP_IMM: begin data_1_d = r1;              data_2_d = bus.io_imm;      end
                MODE_AUIPC:  begin data_1_d = bus.io_pc_count; data_2_d = bus.io_imm;      end
                MODE_LOAD:   begin data_1_d = bus.io_mem_data; data_2_d = '0;              end
                MODE_OP:     begin data_1_d = r1;              data_2_d = r2;              end
                MODE_LINK:   begin data_1_d = bus.io_pc_count; data_2_d = XLEN'(PC_STEP);  end
                MODE_LUI:    begin data_1_d = '0;              data_2_d = bus.io_imm;      end
                MODE_ILL6, MODE_ILL7: begin
                    data_1_d  = '0;
                    data_2_d  = '0;
                    illegal_d = 1'b1;
                end
                default:     begin data_1_d = '0;              data_2_d = '0;              end
            endcase
        end else if (out_fire) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q   <= 1'b0;
            data_1_q  <= '0;
            data_2_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q   <= valid_d;
            data_1_q  <= data_1_d;
            data_2_q  <= data_2_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.io_in_ready  = in_ready;
    assign bus.io_out_valid = valid_q;
    assign bus.io_data_1    = data_1_q;
    assign bus.io_data_2    = data_2_q;
    assign bus.io_illegal   = illegal_q;

`ifdef OPERAND_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [31:0] stat_stall_q,  stat_stall_d;

    // Both counters wrap naturally at 32 bits.
    always_comb begin
        stat_issued_d = stat_issued_q;
        stat_stall_d  = stat_stall_q;
        if (out_fire)                        stat_issued_d = stat_issued_q + 32'd1;
        if (valid_q && !bus.io_out_ready)    stat_stall_d  = stat_stall_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign bus.io_stat_issued = stat_issued_q;
    assign bus.io_stat_stall  = stat_stall_q;
`endif

endmodule
